// File: rtl/sta_prbs_pkg.sv
// Shared types and constants for the PRBS7 checker.
package sta_prbs_pkg;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_e;

   // x^7 + x^6 + 1: predicted bit is the XOR of the two oldest bits
   localparam int PRBS_ORDER = 7;
   localparam int TAP_HI     = 6;
   localparam int TAP_LO     = 5;
   localparam int FILL_LEN   = 7;
   localparam int BIT_CNT_W  = 32;

endpackage

// File: rtl/prbs7_lfsr.sv
// PRBS7 shift register: shifts in either an external bit or its own prediction.
module prbs7_lfsr
   import sta_prbs_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic shift_en_i,
   input  logic sel_pred_i,
   input  logic ext_bit_i,
   output logic pred_o,
   output logic zero_o
);

   logic [PRBS_ORDER-1:0] lfsr_q;
   logic [PRBS_ORDER-1:0] lfsr_d;
   logic                  in_bit;

   always_comb begin
      pred_o = lfsr_q[TAP_HI] ^ lfsr_q[TAP_LO];
      zero_o = (lfsr_q == '0);
      in_bit = sel_pred_i ? pred_o : ext_bit_i;
      lfsr_d = lfsr_q;
      if (shift_en_i) begin
         lfsr_d = {lfsr_q[PRBS_ORDER-2:0], in_bit};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= '0;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

endmodule

// File: rtl/sta_prbs_checker.sv
// PRBS7 stream checker with lock FSM, windowed loss-of-lock and saturating error count.
// Optional bit_count output when STA_PRBS_CHECKER_BITCNT_EN is defined.
module sta_prbs_checker
   import sta_prbs_pkg::*;
#(
   parameter int LOCK_CNT  = 16,
   parameter int WINDOW    = 64,
   parameter int LOSS_ERR  = 4,
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din,
   input  logic                 din_valid,
   input  logic                 clr_cnt,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_count
`ifdef STA_PRBS_CHECKER_BITCNT_EN
   ,
   output logic [BIT_CNT_W-1:0] bit_count
`endif
);

   localparam logic [2:0]  FILL_C   = 3'(FILL_LEN);
   localparam logic [7:0]  LOCK_C   = 8'(LOCK_CNT);
   localparam logic [15:0] WINDOW_C = 16'(WINDOW);
   localparam logic [15:0] LOSS_C   = 16'(LOSS_ERR);

   state_e                state_q, state_d;
   logic [2:0]            fill_q, fill_d;
   logic [7:0]            match_q, match_d;
   logic [15:0]           win_cnt_q, win_cnt_d;
   logic [15:0]           win_err_q, win_err_d;
   logic                  locked_q, locked_d;
   logic                  err_pulse_q, err_pulse_d;
   logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
   logic                  pred;
   logic                  lfsr_zero;
   logic                  mismatch;
   logic                  err_inc;

   prbs7_lfsr u_lfsr (
      .clk        (clk),
      .rst        (rst),
      .shift_en_i (din_valid),
      .sel_pred_i (state_q == LOCKED),
      .ext_bit_i  (din),
      .pred_o     (pred),
      .zero_o     (lfsr_zero)
   );

   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      match_d     = match_q;
      win_cnt_d   = win_cnt_q;
      win_err_d   = win_err_q;
      err_pulse_d = 1'b0;
      err_inc     = 1'b0;
      mismatch    = (din != pred);

      if (din_valid) begin
         case (state_q)
            SEARCH: begin
               if (fill_q != FILL_C) begin
                  fill_d = fill_q + 3'd1;
               end else begin
                  // An all-zero register predicts zeros forever, so it never earns a match
                  if (lfsr_zero || mismatch) begin
                     match_d = '0;
                  end else begin
                     match_d = match_q + 8'd1;
                  end
                  if (match_d == LOCK_C) begin
                     state_d   = LOCKED;
                     win_cnt_d = '0;
                     win_err_d = '0;
                  end
               end
            end
            LOCKED: begin
               err_pulse_d = mismatch;
               err_inc     = mismatch;
               win_cnt_d   = win_cnt_q + 16'd1;
               win_err_d   = win_err_q + {15'd0, mismatch};
               if (win_err_d == LOSS_C) begin
                  state_d   = SEARCH;
                  fill_d    = '0;
                  match_d   = '0;
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else if (win_cnt_d == WINDOW_C) begin
                  win_cnt_d = '0;
                  win_err_d = '0;
               end
            end
            default: state_d = SEARCH;
         endcase
      end

      // Clear takes effect first so a same-cycle error still lands in the count
      err_count_d = clr_cnt ? '0 : err_count_q;
      if (err_inc && (err_count_d != '1)) begin
         err_count_d = err_count_d + 1'b1;
      end

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SEARCH;
         fill_q      <= '0;
         match_q     <= '0;
         win_cnt_q   <= '0;
         win_err_q   <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         win_cnt_q   <= win_cnt_d;
         win_err_q   <= win_err_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;

`ifdef STA_PRBS_CHECKER_BITCNT_EN
   logic [BIT_CNT_W-1:0] bit_count_q, bit_count_d;

   always_comb begin
      bit_count_d = clr_cnt ? '0 : bit_count_q;
      if (din_valid && (state_q == LOCKED) && (bit_count_d != '1)) begin
         bit_count_d = bit_count_d + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_count_q <= '0;
      end else begin
         bit_count_q <= bit_count_d;
      end
   end

   assign bit_count = bit_count_q;
`else
   // Without the bit counter only the raw error count is reported.
`endif

endmodule

// File: tb/tb_sta_prbs_checker.sv
// Self-checking bench for sta_prbs_checker: per-cycle scoreboard of expected outputs.
// Checks bit_count too when STA_PRBS_CHECKER_BITCNT_EN is defined.
module tb_sta_prbs_checker;

   logic        clk;
   logic        rst;
   logic        din;
   logic        dinValid;
   logic        clrCnt;
   logic        locked;
   logic        errPulse;
   logic [15:0] errCount;
   logic        locked4;
   logic        errPulse4;
   logic [3:0]  errCount4;
`ifdef STA_PRBS_CHECKER_BITCNT_EN
   logic [31:0] bitCount;
   logic [31:0] bitCount4;
`endif

   typedef struct {
      bit expLocked;
      bit expPulse;
      int expCount;
      int step;
   } exp_t;

   typedef struct {
      bit valid;
      bit invert;
      bit clr;
      bit expLocked;
      bit expPulse;
      int expCount;
   } vec_t;

   exp_t     sbQ[$];
   vec_t     vecs[11];
   int       errors = 0;
   int       checks = 0;
   int       stepNo = 0;
   bit [6:0] genQ   = 7'h7F;

   sta_prbs_checker dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (dinValid),
      .clr_cnt   (clrCnt),
      .locked    (locked),
      .err_pulse (errPulse),
      .err_count (errCount)
`ifdef STA_PRBS_CHECKER_BITCNT_EN
      ,
      .bit_count (bitCount)
`endif
   );

   sta_prbs_checker #(.ERR_CNT_W(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (dinValid),
      .clr_cnt   (clrCnt),
      .locked    (locked4),
      .err_pulse (errPulse4),
      .err_count (errCount4)
`ifdef STA_PRBS_CHECKER_BITCNT_EN
      ,
      .bit_count (bitCount4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of stimulus at the falling edge and queue what the DUT must show after the next rising edge
   task automatic applyStimulus(input bit r, input bit v, input bit inv, input bit c, input bit z,
                                input bit eL, input bit eP, input int eC);
      bit b;
      exp_t e;
      @(negedge clk);
      rst      = r;
      dinValid = v;
      clrCnt   = c;
      if (z) begin
         din = 1'b0;
      end else if (v) begin
         b    = genQ[6] ^ genQ[5];
         genQ = {genQ[5:0], b};
         din  = b ^ inv;
      end else begin
         din = 1'($urandom_range(0, 1));
      end
      stepNo      = stepNo + 1;
      e.expLocked = eL;
      e.expPulse  = eP;
      e.expCount  = eC;
      e.step      = stepNo;
      sbQ.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      e = sbQ.pop_front();
      checks = checks + 3;
      if (locked !== e.expLocked) begin
         errors = errors + 1;
         $display("[TB] FAIL locked step %0d: got %0b want %0b", e.step, locked, e.expLocked);
      end
      if (errPulse !== e.expPulse) begin
         errors = errors + 1;
         $display("[TB] FAIL err_pulse step %0d: got %0b want %0b", e.step, errPulse, e.expPulse);
      end
      if (int'(errCount) != e.expCount) begin
         errors = errors + 1;
         $display("[TB] FAIL err_count step %0d: got %0d want %0d", e.step, errCount, e.expCount);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (sbQ.size() > 0) begin
         checkOutput();
      end
   end

   // Clean stream until lock: 22 bits unlocked, the 23rd bit's edge raises locked
   task automatic relock(input int cnt);
      for (int i = 0; i < 22; i++) begin
         applyStimulus(0, 1, 0, 0, 0, 0, 0, cnt);
      end
      applyStimulus(0, 1, 0, 0, 0, 1, 0, cnt);
   endtask

   task automatic doReset();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst      = 1'b1;
      din      = 1'b0;
      dinValid = 1'b0;
      clrCnt   = 1'b0;

      // Single-error, clear-with-error and loss-on-fourth-error sequence right after lock
      vecs[0]  = '{1, 0, 0, 1, 0, 0};
      vecs[1]  = '{1, 1, 0, 1, 1, 1};
      vecs[2]  = '{1, 0, 0, 1, 0, 1};
      vecs[3]  = '{0, 0, 0, 1, 0, 1};
      vecs[4]  = '{1, 1, 1, 1, 1, 1};
      vecs[5]  = '{1, 0, 0, 1, 0, 1};
      vecs[6]  = '{1, 0, 1, 1, 0, 0};
      vecs[7]  = '{1, 1, 0, 1, 1, 1};
      vecs[8]  = '{1, 0, 0, 1, 0, 1};
      vecs[9]  = '{1, 1, 0, 0, 1, 2};
      vecs[10] = '{1, 0, 0, 0, 0, 2};

      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] clean lock and 1000 clean bits");
      relock(0);
      for (int i = 0; i < 1000; i++) applyStimulus(0, 1, 0, 0, 0, 1, 0, 0);
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] vector table");
      relock(0);
      foreach (vecs[i]) begin
         applyStimulus(0, vecs[i].valid, vecs[i].invert, vecs[i].clr, 0,
                       vecs[i].expLocked, vecs[i].expPulse, vecs[i].expCount);
      end

      $display("[TB] four errors in one window, relock, reset while locked");
      doReset();
      relock(0);
      for (int e = 1; e <= 4; e++) begin
         applyStimulus(0, 1, 0, 0, 0, 1, 0, e - 1);
         applyStimulus(0, 1, 1, 0, 0, (e < 4), 1, e);
      end
      relock(4);
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);

      $display("[TB] stuck-at-zero input");
      doReset();
      for (int i = 0; i < 200; i++) applyStimulus(0, 1, 0, 0, 1, 0, 0, 0);

      $display("[TB] alternating valid");
      doReset();
      for (int i = 1; i <= 23; i++) begin
         applyStimulus(0, 1, 0, 0, 0, (i == 23), 0, 0);
         applyStimulus(0, 0, 0, 0, 0, (i == 23), 0, 0);
      end

      $display("[TB] error counter saturation");
      doReset();
      relock(0);
      for (int e = 1; e <= 20; e++) begin
         for (int i = 0; i < 69; i++) applyStimulus(0, 1, 0, 0, 0, 1, 0, e - 1);
         applyStimulus(0, 1, 1, 0, 0, 1, 1, e);
      end
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 20);
      @(posedge clk);
      #2;
      checks = checks + 2;
      if (errCount4 !== 4'hF) begin
         errors = errors + 1;
         $display("[TB] FAIL err_count_sat4: got %0d want 15", errCount4);
      end
      if (locked4 !== 1'b1) begin
         errors = errors + 1;
         $display("[TB] FAIL locked_sat4: got %0b want 1", locked4);
      end

`ifdef STA_PRBS_CHECKER_BITCNT_EN
      $display("[TB] bit counter");
      doReset();
      @(posedge clk);
      #2;
      checks = checks + 1;
      if (bitCount !== 32'd0) begin
         errors = errors + 1;
         $display("[TB] FAIL bit_count_reset: got %0d want 0", bitCount);
      end
      relock(0);
      applyStimulus(0, 1, 0, 1, 0, 1, 0, 0);
      for (int i = 0; i < 99; i++) applyStimulus(0, 1, 0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
      @(posedge clk);
      #2;
      checks = checks + 1;
      if (bitCount !== 32'd100) begin
         errors = errors + 1;
         $display("[TB] FAIL bit_count_100: got %0d want 100", bitCount);
      end
`endif

      for (int i = 0; i < 10 && sbQ.size() > 0; i++) @(posedge clk);
      #2;
      checks = checks + 1;
      if (sbQ.size() != 0) begin
         errors = errors + 1;
         $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", sbQ.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
